vga_timing_gen: RTL

Produces 640x480@60 VGA raster timing from the 100 MHz board clock. Generates hsync, vsync, the display-interval qualifier, pixel coordinates, and a square_on mask for one SQ_SIZE x SQ_SIZE square. The square's position is taken from inputs and latched once per frame, so it never tears. It drives the pixel renderer, which turns square_on and indisplayinterval into 12-bit RGB.

---
 rtl/vga_pkg.sv | 53 +++++
 rtl/vga_pixel_div.sv | 28 ++
 rtl/vga_timing_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster constants and the registered timing-output bundle.
// Used by the timing generator and the pixel renderer.
package vga_pkg;

  localparam int unsigned VGA_CLK_DIV   = 4;
  localparam int unsigned VGA_H_DISPLAY = 640;
  localparam int unsigned VGA_H_FRONT   = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BACK    = 48;
  localparam int unsigned VGA_V_DISPLAY = 480;
  localparam int unsigned VGA_V_FRONT   = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BACK    = 33;
  localparam int unsigned VGA_SQ_SIZE   = 32;

  localparam int unsigned VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int unsigned VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned SQ_X_W  = 10;
  localparam int unsigned SQ_Y_W  = 9;
  // One bit wider than coordinates so lo + len never wraps.
  localparam int unsigned CMP_W   = 11;

  typedef struct packed {
    logic               hsync;
    logic               vsync;
    logic               disp;
    logic               square_on;
    logic               frame_start;
    logic               pixel_tick;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vga_timing_t;

  localparam vga_timing_t TIMING_RESET = '{
    hsync:       1'b1,
    vsync:       1'b1,
    disp:        1'b0,
    square_on:   1'b0,
    frame_start: 1'b0,
    pixel_tick:  1'b0,
    x:           '0,
    y:           '0
  };

  function automatic logic in_span(input logic [CMP_W-1:0] p,
                                   input logic [CMP_W-1:0] lo,
                                   input int unsigned      len);
    return (p >= lo) && (p < lo + CMP_W'(len));
  endfunction

endpackage

// File: rtl/vga_pixel_div.sv
// Pixel-rate divider: free-running 0..CLK_DIV-1 counter with a last-phase tick.
module vga_pixel_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [$clog2(CLK_DIV)-1:0] div_o,
  output logic                       tick_c
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;

  assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));
  assign div_o  = div_q;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (tick_c) div_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing with a per-frame latched square mask.
// Outputs are registered decodes of (div, h, v), one clk behind the counters.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned H_DISPLAY = VGA_H_DISPLAY,
  parameter int unsigned H_FRONT   = VGA_H_FRONT,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BACK    = VGA_H_BACK,
  parameter int unsigned V_DISPLAY = VGA_V_DISPLAY,
  parameter int unsigned V_FRONT   = VGA_V_FRONT,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BACK    = VGA_V_BACK,
  parameter int unsigned SQ_SIZE   = VGA_SQ_SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SQ_X_W-1:0]  sq_x_in,
  input  logic [SQ_Y_W-1:0]  sq_y_in,
  output logic               hsync,
  output logic               vsync,
  output logic               indisplayinterval,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               square_on,
  output logic               frame_start,
  output logic               pixel_tick
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned SQX_MAX  = H_DISPLAY - SQ_SIZE;
  localparam int unsigned SQY_MAX  = V_DISPLAY - SQ_SIZE;
  localparam int unsigned DIV_W    = $clog2(CLK_DIV);

  logic [DIV_W-1:0]   div;
  logic               tick_c;
  logic               line_end_c;
  logic               disp_c;
  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
  logic [SQ_X_W-1:0]  sqx_q, sqx_d;
  logic [SQ_Y_W-1:0]  sqy_q, sqy_d;
  vga_timing_t        dec_q, dec_d;

  vga_pixel_div #(.CLK_DIV(CLK_DIV)) u_pixel_div (
    .clk    (clk),
    .reset  (reset),
    .div_o  (div),
    .tick_c (tick_c)
  );

  assign line_end_c = tick_c && (h_q == COORD_W'(H_TOTAL - 1));

  // Raster counters; square position is captured as the last visible line ends.
  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    sqx_d = sqx_q;
    sqy_d = sqy_q;
    if (tick_c) begin
      h_d = h_q + COORD_W'(1);
      if (line_end_c) begin
        h_d = '0;
        v_d = (v_q == COORD_W'(V_TOTAL - 1)) ? '0 : v_q + COORD_W'(1);
        if (v_q == COORD_W'(V_DISPLAY - 1)) begin
          sqx_d = (sq_x_in > SQ_X_W'(SQX_MAX)) ? SQ_X_W'(SQX_MAX) : sq_x_in;
          sqy_d = (sq_y_in > SQ_Y_W'(SQY_MAX)) ? SQ_Y_W'(SQY_MAX) : sq_y_in;
        end
      end
    end
  end

  assign disp_c = (h_q < COORD_W'(H_DISPLAY)) && (v_q < COORD_W'(V_DISPLAY));

  always_comb begin
    dec_d             = TIMING_RESET;
    dec_d.hsync       = !((h_q >= COORD_W'(HS_START)) && (h_q < COORD_W'(HS_END)));
    dec_d.vsync       = !((v_q >= COORD_W'(VS_START)) && (v_q < COORD_W'(VS_END)));
    dec_d.disp        = disp_c;
    dec_d.square_on   = disp_c
                        && in_span(CMP_W'(h_q), CMP_W'(sqx_q), SQ_SIZE)
                        && in_span(CMP_W'(v_q), CMP_W'(sqy_q), SQ_SIZE);
    dec_d.frame_start = (div == '0) && (h_q == '0) && (v_q == '0);
    dec_d.pixel_tick  = tick_c;
    dec_d.x           = h_q;
    dec_d.y           = v_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q   <= '0;
      v_q   <= '0;
      sqx_q <= '0;
      sqy_q <= '0;
      dec_q <= TIMING_RESET;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      sqx_q <= sqx_d;
      sqy_q <= sqy_d;
      dec_q <= dec_d;
    end
  end

  assign hsync             = dec_q.hsync;
  assign vsync             = dec_q.vsync;
  assign indisplayinterval = dec_q.disp;
  assign square_on         = dec_q.square_on;
  assign frame_start       = dec_q.frame_start;
  assign pixel_tick        = dec_q.pixel_tick;
  assign pixel_x           = dec_q.x;
  assign pixel_y           = dec_q.y;

endmodule
